memory_access_master: RTL and testbench
=======================================

# memory_access_master

Initiator side of the memory bus: it is the only block that drives `memory_unit`'s `ctrl_bus`, `addr_bus` and `write_bus`, and the only block that consumes `read_bus`. It turns CPU state-machine requests (single or burst, read or write) into correctly timed memory-bus cycles. It absorbs the memory's one-cycle registered-address read latency and gives the CPU a valid/ready response stream with back-pressure.

## Interface
Parameters:
- `ADDR_W`, default 8: address and data width; must equal the width of `DEFAULT_TYPE`.

Ports:
- `CLOCK`  in  1: single clock; all state changes on its rising edge.
- `RESET`  in  1: asynchronous, active-low.
- `req_valid`  in  1: CPU presents a request.
- `req_ready`  out  1: master accepts a request; high only in IDLE.
- `req_write`  in  1: 1 = write burst, 0 = read burst.
- `req_addr`  in  DEFAULT_TYPE: burst base address.
- `req_len`  in  DEFAULT_TYPE: beats minus 1; 0..255 encodes 1..256 beats.
- `wr_valid`  in  1: write beat data valid.
- `wr_data`  in  DEFAULT_TYPE: write beat data.
- `wr_ready`  out  1: write beat accepted; high only in WRITE.
- `rsp_valid`  out  1: read beat data valid.
- `rsp_data`  out  DEFAULT_TYPE: read beat data.
- `rsp_last`  out  1: final read beat of the burst.
- `rsp_ready`  in  1: CPU accepts the read beat.
- `ctrl_bus`  out  MEMORY_FLAG_TYPE: memory command.
- `addr_bus`  out  DEFAULT_TYPE: memory address.
- `write_bus`  out  DEFAULT_TYPE: memory write data.
- `read_bus`  in  DEFAULT_TYPE: memory read data.

## Operation
- The state machine has three states: IDLE, READ and WRITE.
- Registers:
  - `state`
  - `addr_ptr`: next address to issue.
  - `issue_left`: beats still to issue.
  - `last_addr`: last issued address.
  - `pend`: a read beat is in flight or held.
  - `pend_last`: the pending beat is the final one.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: load `addr_ptr`=`req_addr` and `issue_left`=`req_len`+1 (9-bit count).
  - Go to WRITE if `req_write`=1, otherwise READ.
  - `ctrl_bus`=MEMORY_NONE.
- **WRITE**
  - `wr_ready`=1.
  - On `wr_valid` in the same cycle:
    - drive `ctrl_bus`=MEMORY_WRITE, `addr_bus`=`addr_ptr`, `write_bus`=`wr_data`;
    - increment `addr_ptr` and decrement `issue_left`;
    - on the beat where `issue_left`=1, go to IDLE.
  - Without `wr_valid`: `ctrl_bus`=MEMORY_NONE, no state change.
- **READ**
  - `ctrl_bus`=MEMORY_READ.
  - `stall` = `pend` & !`rsp_ready`.
  - While stalled: `addr_bus`=`last_addr`. Re-presenting the address keeps the memory's latched address, and therefore `read_bus`, stable. Nothing is issued.
  - Otherwise, if `issue_left`≠0, issue the next beat:
    - `addr_bus`=`addr_ptr`;
    - at the edge, set `last_addr`=`addr_ptr`, increment `addr_ptr`, decrement `issue_left`;
    - set `pend`=1, and set `pend_last`=1 if `issue_left` was 1.
  - Otherwise, if nothing is issued and the pending beat is taken: `pend`=0.
  - `rsp_valid`=`pend`, `rsp_data`=`read_bus` (combinational), `rsp_last`=`pend` & `pend_last`.
  - When the beat with `rsp_last` is accepted (`rsp_ready`=1), go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W: 0xFF+1 = 0x00. No error is raised.
- Every bus output is a combinational decode of registered state plus handshake inputs. `write_bus` is 0 whenever it is not MEMORY_WRITE.
- Requests arriving outside IDLE are ignored; `req_ready`=0.

## Timing
- Reset values, immediate on `RESET`=0 and held while low:
  - state registers: `state`=IDLE, `pend`=0, `pend_last`=0, `addr_ptr`=0, `last_addr`=0, `issue_left`=0;
  - outputs: `ctrl_bus`=MEMORY_NONE, `addr_bus`=0, `write_bus`=0, `rsp_valid`=0, `wr_ready`=0, `req_ready`=1.
- Reset asserted mid-burst aborts it. No MEMORY_WRITE is driven from the assertion onward, and no response is delivered.
- Request to first bus cycle: 1 cycle. The request is accepted at edge N, and the first address or write is driven in cycle N+1.
- Read latency: an address issued in cycle K returns its data with `rsp_valid`=1 in cycle K+1.
- Throughput is 1 beat per cycle when `rsp_ready` and `wr_valid` are held high.
- A write takes effect at the edge that ends its MEMORY_WRITE cycle.
- After a read burst ends at edge E, a new request can be accepted in cycle E+1. There is no bus turnaround bubble beyond the IDLE cycle.
- In the same READ cycle, a beat may be taken while the next is issued; `pend` stays 1.

## Structure
- Add `MEM_MASTER_STATE_TYPE` {IDLE, READ, WRITE} to `typedef_collection.sv`.
- `MEMORY_FLAG_TYPE` there must define MEMORY_NONE, MEMORY_READ and MEMORY_WRITE, and `DEFAULT_TYPE` stays the shared data/address type.
- No sub-modules; a single module in `memory_access_master.sv`.
- The bench instantiates it against `memory_unit`.

## Test plan
- Reset, then a single write of 0x5A to 0x10, then a single read of 0x10 → `rsp_data`=0x5A with `rsp_last`=1, one cycle after the read address is issued.
- Write burst base 0xFE, `req_len`=3, data 1,2,3,4 → memory[0xFE]=1, [0xFF]=2, [0x00]=3, [0x01]=4 (wrap).
- Read burst base 0x00, `req_len`=3, `rsp_ready`=1 → 4 consecutive `rsp_valid` cycles of 3,4,…; `rsp_last` only on the 4th beat; `req_ready`=1 in the following cycle.
- Same read burst with `rsp_ready` dropped for 3 cycles on beat 2 → `rsp_data` held stable, `addr_bus` repeats, no beat lost or duplicated.
- Write burst with `wr_valid` gaps → MEMORY_WRITE only in `wr_valid` cycles; `req_len`=255 writes exactly 256 bytes.
- `RESET` low during a write burst, with beat 2 presented → no further writes; outputs at reset values immediately; memory unchanged beyond beat 1.

Source files
------------

// File: rtl/memory_access_master_pkg.sv
// ---------------------------------------------------------------------------
// memory_access_master_pkg
// Shared types for the memory bus initiator and the memory it drives.
//   DEFAULT_TYPE          : common data/address word of the memory bus
//   MEMORY_FLAG_TYPE      : command presented on ctrl_bus
//   MEM_MASTER_STATE_TYPE : state encoding of memory_access_master
// ---------------------------------------------------------------------------
package memory_access_master_pkg;

    typedef logic [7:0] DEFAULT_TYPE;

    typedef enum logic [1:0] {
        MEMORY_NONE  = 2'd0,
        MEMORY_READ  = 2'd1,
        MEMORY_WRITE = 2'd2
    } MEMORY_FLAG_TYPE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } MEM_MASTER_STATE_TYPE;

endpackage

// File: rtl/memory_unit.sv
// ---------------------------------------------------------------------------
// memory_unit
// Single-port memory with a registered read address. A MEMORY_READ command
// latches addr_bus at the rising edge and the addressed word appears on
// read_bus during the following cycle. A MEMORY_WRITE command stores
// write_bus at addr_bus on the edge ending the cycle.
// Ports:
//   CLOCK     in  : clock
//   ctrl_bus  in  : command (NONE / READ / WRITE)
//   addr_bus  in  : address
//   write_bus in  : write data
//   read_bus  out : data at the latched read address
// ---------------------------------------------------------------------------
module memory_unit
    import memory_access_master_pkg::*;
(
    input  logic            CLOCK,
    input  MEMORY_FLAG_TYPE ctrl_bus,
    input  DEFAULT_TYPE     addr_bus,
    input  DEFAULT_TYPE     write_bus,
    output DEFAULT_TYPE     read_bus
);

    localparam int DEPTH = 2 ** $bits(DEFAULT_TYPE);

    DEFAULT_TYPE mem [DEPTH];
    DEFAULT_TYPE latched_addr;

    // The read address only moves on a read command, so re-presenting the
    // same address during a stall keeps read_bus stable.
    always_ff @(posedge CLOCK) begin
        if (ctrl_bus == MEMORY_READ) begin
            latched_addr <= addr_bus;
        end
        if (ctrl_bus == MEMORY_WRITE) begin
            mem[addr_bus] <= write_bus;
        end
    end

    assign read_bus = mem[latched_addr];

endmodule

// File: rtl/memory_access_master.sv
// ---------------------------------------------------------------------------
// memory_access_master
// Bus initiator for memory_unit. Converts CPU burst requests (read or write,
// 1..256 beats) into memory bus cycles and returns read data through a
// valid/ready stream that absorbs the memory's one-cycle read latency.
// Ports:
//   CLOCK, RESET (async, active-low)
//   req_valid/req_ready/req_write/req_addr/req_len : burst request
//   wr_valid/wr_data/wr_ready                      : write beat stream
//   rsp_valid/rsp_data/rsp_last/rsp_ready          : read beat stream
//   ctrl_bus/addr_bus/write_bus                    : memory command side
//   read_bus                                       : memory read data
// ADDR_W must equal the width of DEFAULT_TYPE.
// ---------------------------------------------------------------------------
module memory_access_master
    import memory_access_master_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  DEFAULT_TYPE     req_addr,
    input  DEFAULT_TYPE     req_len,
    input  logic            wr_valid,
    input  DEFAULT_TYPE     wr_data,
    output logic            wr_ready,
    output logic            rsp_valid,
    output DEFAULT_TYPE     rsp_data,
    output logic            rsp_last,
    input  logic            rsp_ready,
    output MEMORY_FLAG_TYPE ctrl_bus,
    output DEFAULT_TYPE     addr_bus,
    output DEFAULT_TYPE     write_bus,
    input  DEFAULT_TYPE     read_bus
);

    // One extra bit so a 256-beat burst can be counted.
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);
    localparam DEFAULT_TYPE     ADDR_ONE  = DEFAULT_TYPE'(1);

    MEM_MASTER_STATE_TYPE state, next_state;
    DEFAULT_TYPE          addr_ptr;
    DEFAULT_TYPE          last_addr;
    logic [ADDR_W:0]      issue_left;
    logic                 pend;
    logic                 pend_last;

    logic stall;
    logic issue_beat;
    logic beat_taken;

    // A held read beat that the CPU refuses blocks new issues; the memory is
    // then fed the previous address again so its output does not move.
    assign stall      = pend & ~rsp_ready;
    assign issue_beat = (state == READ) & ~stall & (issue_left != '0);
    assign beat_taken = pend & rsp_ready;

    // State register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_valid && (issue_left == COUNT_ONE)) begin
                    next_state = IDLE;
                end
            end
            READ: begin
                // pend_last is only set once every beat has been issued,
                // so taking that beat ends the burst.
                if (beat_taken && pend_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Burst bookkeeping. pend_last is cleared on acceptance so that a new
    // burst does not inherit the final-beat marker of the previous one.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            addr_ptr   <= '0;
            last_addr  <= '0;
            issue_left <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_ptr   <= req_addr;
                        issue_left <= {1'b0, req_len} + COUNT_ONE;
                        pend       <= 1'b0;
                        pend_last  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        addr_ptr   <= addr_ptr + ADDR_ONE;
                        issue_left <= issue_left - COUNT_ONE;
                    end
                end
                READ: begin
                    if (issue_beat) begin
                        last_addr  <= addr_ptr;
                        addr_ptr   <= addr_ptr + ADDR_ONE;
                        issue_left <= issue_left - COUNT_ONE;
                        pend       <= 1'b1;
                        pend_last  <= (issue_left == COUNT_ONE);
                    end else if (beat_taken) begin
                        pend <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and handshake outputs decoded from state plus handshake inputs.
    always_comb begin
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        ctrl_bus  = MEMORY_NONE;
        addr_bus  = '0;
        write_bus = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    ctrl_bus  = MEMORY_WRITE;
                    addr_bus  = addr_ptr;
                    write_bus = wr_data;
                end
            end
            READ: begin
                ctrl_bus  = MEMORY_READ;
                addr_bus  = stall ? last_addr : addr_ptr;
                rsp_valid = pend;
                rsp_data  = read_bus;
                rsp_last  = pend & pend_last;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_memory_access_master.sv
// ---------------------------------------------------------------------------
// tb_memory_access_master
// Drives memory_access_master against memory_unit. A bench-side memory image
// plus queues of expected bus writes and read responses describe what the
// bus must show; a compare process checks every cycle against them, and
// directed literal checks pin reset values, latency and stall behaviour.
// ---------------------------------------------------------------------------
module tb_memory_access_master;
    import memory_access_master_pkg::*;

    logic            CLOCK;
    logic            RESET;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    DEFAULT_TYPE     req_addr;
    DEFAULT_TYPE     req_len;
    logic            wr_valid;
    DEFAULT_TYPE     wr_data;
    logic            wr_ready;
    logic            rsp_valid;
    DEFAULT_TYPE     rsp_data;
    logic            rsp_last;
    logic            rsp_ready;
    MEMORY_FLAG_TYPE ctrl_bus;
    DEFAULT_TYPE     addr_bus;
    DEFAULT_TYPE     write_bus;
    DEFAULT_TYPE     read_bus;

    int checks = 0;
    int errors = 0;

    DEFAULT_TYPE model_mem [256];
    DEFAULT_TYPE wbuf [256];
    DEFAULT_TYPE exp_wr_addr [$];
    DEFAULT_TYPE exp_wr_data [$];
    DEFAULT_TYPE exp_rsp_data [$];
    bit          exp_rsp_last [$];
    DEFAULT_TYPE first_data;

    memory_access_master #(.ADDR_W(8)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_ready (rsp_ready),
        .ctrl_bus  (ctrl_bus),
        .addr_bus  (addr_bus),
        .write_bus (write_bus),
        .read_bus  (read_bus)
    );

    memory_unit mem_u (
        .CLOCK     (CLOCK),
        .ctrl_bus  (ctrl_bus),
        .addr_bus  (addr_bus),
        .write_bus (write_bus),
        .read_bus  (read_bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input DEFAULT_TYPE addr, input DEFAULT_TYPE len);
        req_valid = valid;
        req_write = write;
        req_addr  = addr;
        req_len   = len;
    endtask

    // Every memory write and every read beat on the bus must match, in
    // order, what the queued transactions say; write_bus must be zero
    // whenever no write is driven; a refused beat must keep its data.
    always @(negedge CLOCK) begin
        if (RESET) begin
            if (ctrl_bus == MEMORY_WRITE) begin
                if (exp_wr_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected write: addr %0h data %0h, expected no write",
                             addr_bus, write_bus);
                end else begin
                    checkOutput("write addr", addr_bus, exp_wr_addr.pop_front());
                    checkOutput("write data", write_bus, exp_wr_data.pop_front());
                end
            end else begin
                checkOutput("write_bus idle zero", write_bus, 0);
            end
            if (rsp_valid) begin
                if (exp_rsp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected response: data %0h, expected none", rsp_data);
                end else begin
                    checkOutput("rsp data", rsp_data, exp_rsp_data[0]);
                    checkOutput("rsp last", rsp_last, exp_rsp_last[0]);
                    if (rsp_ready) begin
                        void'(exp_rsp_data.pop_front());
                        void'(exp_rsp_last.pop_front());
                    end
                end
            end
        end
    end

    // Write burst of wbuf[0..len]; with gaps, wr_valid drops for one cycle
    // before every beat with index%16==5 and for two cycles before beat 100.
    task automatic doWrite(input DEFAULT_TYPE base, input int len, input bit gaps);
        for (int i = 0; i <= len; i++) begin
            exp_wr_addr.push_back(DEFAULT_TYPE'(base + i));
            exp_wr_data.push_back(wbuf[i]);
            model_mem[DEFAULT_TYPE'(base + i)] = wbuf[i];
        end
        @(posedge CLOCK); #1;
        applyStimulus(1'b1, 1'b1, base, DEFAULT_TYPE'(len));
        @(posedge CLOCK); #1;
        req_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            int gap_cycles;
            gap_cycles = 0;
            if (gaps && (i % 16 == 5)) gap_cycles = 1;
            if (gaps && (i == 100)) gap_cycles = 2;
            for (int g = 0; g < gap_cycles; g++) begin
                wr_valid = 1'b0;
                wr_data  = ~wbuf[i];
                @(posedge CLOCK); #1;
            end
            wr_valid = 1'b1;
            wr_data  = wbuf[i];
            @(posedge CLOCK); #1;
        end
        wr_valid = 1'b0;
        wr_data  = '0;
        @(negedge CLOCK);
        checkOutput("req_ready after write burst", req_ready, 1);
    endtask

    // Read burst; rsp_ready is held low for stall_cycles cycles once
    // stall_beat beats have been accepted. The burst must take exactly
    // len+2+stall_cycles cycles from acceptance (issue cycle plus one
    // cycle per beat plus the stall).
    task automatic doRead(input DEFAULT_TYPE base, input int len,
                          input int stall_beat, input int stall_cycles);
        int accepted;
        int stalled;
        int cyc;
        bit in_stall;
        accepted = 0;
        stalled  = 0;
        cyc      = 0;
        for (int i = 0; i <= len; i++) begin
            exp_rsp_data.push_back(model_mem[DEFAULT_TYPE'(base + i)]);
            exp_rsp_last.push_back(i == len);
        end
        @(posedge CLOCK); #1;
        applyStimulus(1'b1, 1'b0, base, DEFAULT_TYPE'(len));
        while (accepted <= len && cyc < 700) begin
            @(posedge CLOCK); #1;
            req_valid = 1'b0;
            in_stall  = (accepted == stall_beat) && (stalled < stall_cycles);
            rsp_ready = !in_stall;
            @(negedge CLOCK);
            if (in_stall) begin
                stalled++;
                if (rsp_valid)
                    checkOutput("stall addr repeat", addr_bus, DEFAULT_TYPE'(base + stall_beat));
            end
            if (rsp_valid && rsp_ready) begin
                if (accepted == 0) first_data = rsp_data;
                accepted++;
            end
            cyc++;
        end
        if (accepted <= len) begin
            checks++;
            errors++;
            $display("[TB] FAIL read timeout: got %0d beats, expected %0d", accepted, len + 1);
        end
        checkOutput("read burst cycles", cyc, len + 2 + stall_cycles);
        @(posedge CLOCK); #1;
        rsp_ready = 1'b1;
        @(negedge CLOCK);
        checkOutput("req_ready after read burst", req_ready, 1);
        checkOutput("rsp_valid after read burst", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rsp_ready = 1'b1;

        // Reset values
        @(negedge CLOCK);
        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset ctrl_bus", ctrl_bus, MEMORY_NONE);
        checkOutput("reset addr_bus", addr_bus, 0);
        checkOutput("reset write_bus", write_bus, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset wr_ready", wr_ready, 0);
        @(posedge CLOCK); #1;
        RESET = 1'b1;

        // Fill all 256 bytes with a gapped burst, then read them back
        for (int i = 0; i < 256; i++) wbuf[i] = DEFAULT_TYPE'(i * 7 + 3);
        doWrite(8'h00, 255, 1'b1);
        checkOutput("256-beat write drained", exp_wr_addr.size(), 0);
        doRead(8'h00, 255, 999, 0);

        // Single write of 0x5A to 0x10
        exp_wr_addr.push_back(8'h10);
        exp_wr_data.push_back(8'h5A);
        model_mem[8'h10] = 8'h5A;
        @(posedge CLOCK); #1;
        applyStimulus(1'b1, 1'b1, 8'h10, 8'h00);
        @(posedge CLOCK); #1;
        req_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'h5A;
        @(negedge CLOCK);
        checkOutput("single write ctrl", ctrl_bus, MEMORY_WRITE);
        checkOutput("single write addr", addr_bus, 8'h10);
        checkOutput("single write data", write_bus, 8'h5A);
        checkOutput("single write wr_ready", wr_ready, 1);
        checkOutput("single write req_ready", req_ready, 0);
        @(posedge CLOCK); #1;
        wr_valid = 1'b0;
        @(negedge CLOCK);
        checkOutput("after single write req_ready", req_ready, 1);
        checkOutput("after single write ctrl", ctrl_bus, MEMORY_NONE);

        // Single read of 0x10: address in cycle N+1, data in N+2
        exp_rsp_data.push_back(8'h5A);
        exp_rsp_last.push_back(1'b1);
        @(posedge CLOCK); #1;
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
        @(posedge CLOCK); #1;
        req_valid = 1'b0;
        @(negedge CLOCK);
        checkOutput("single read ctrl", ctrl_bus, MEMORY_READ);
        checkOutput("single read addr", addr_bus, 8'h10);
        checkOutput("single read early valid", rsp_valid, 0);
        @(negedge CLOCK);
        checkOutput("single read valid", rsp_valid, 1);
        checkOutput("single read data", rsp_data, 8'h5A);
        checkOutput("single read last", rsp_last, 1);
        @(negedge CLOCK);
        checkOutput("after single read req_ready", req_ready, 1);
        checkOutput("after single read rsp_valid", rsp_valid, 0);

        // Wrapping write burst 0xFE..0x01 = 1,2,3,4
        for (int i = 0; i < 4; i++) wbuf[i] = DEFAULT_TYPE'(i + 1);
        doWrite(8'hFE, 3, 1'b0);
        doRead(8'h00, 3, 999, 0);
        checkOutput("wrap read first beat", first_data, 8'h03);
        doRead(8'hFE, 3, 999, 0);
        checkOutput("wrap read 0xFE beat", first_data, 8'h01);

        // Same read with rsp_ready low for 3 cycles on beat 2
        doRead(8'h00, 3, 1, 3);

        // Reset during a write burst with beat 2 presented
        exp_wr_addr.push_back(8'h20);
        exp_wr_data.push_back(8'hA1);
        model_mem[8'h20] = 8'hA1;
        @(posedge CLOCK); #1;
        applyStimulus(1'b1, 1'b1, 8'h20, 8'h03);
        @(posedge CLOCK); #1;
        req_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'hA1;
        @(posedge CLOCK); #1;
        wr_data = 8'hA2;
        #1;
        RESET = 1'b0;
        #1;
        checkOutput("abort ctrl_bus", ctrl_bus, MEMORY_NONE);
        checkOutput("abort write_bus", write_bus, 0);
        checkOutput("abort addr_bus", addr_bus, 0);
        checkOutput("abort wr_ready", wr_ready, 0);
        checkOutput("abort req_ready", req_ready, 1);
        checkOutput("abort rsp_valid", rsp_valid, 0);
        @(posedge CLOCK);
        @(posedge CLOCK); #1;
        wr_valid = 1'b0;
        RESET    = 1'b1;
        doRead(8'h20, 2, 999, 0);
        checkOutput("abort beat1 landed", first_data, 8'hA1);

        checkOutput("write queue empty", exp_wr_addr.size(), 0);
        checkOutput("response queue empty", exp_rsp_data.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
